// File: rtl/cnn_mem_pkg.sv
// Shared widths and limits for the CNN memory scheduler.
// Window geometry is fixed here so the arbiter, top and bench agree.
package cnn_mem_pkg;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int TAPS     = 25;
    localparam int WR_BURST = 4;
    localparam int WIN_W    = DATA_W * TAPS;
    localparam int STRK_W   = $clog2(WR_BURST + 1);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [WIN_W-1:0]  win_t;

    // Highest base whose 25-word window stays inside the address space.
    localparam addr_t WIN_MAX_BASE = addr_t'((1 << ADDR_W) - TAPS);
    localparam logic [STRK_W-1:0] WR_BURST_C = STRK_W'(WR_BURST);

    function automatic logic win_in_range(input addr_t base);
        return base <= WIN_MAX_BASE;
    endfunction
endpackage

// File: rtl/cnn_mem_scheduler_if.sv
// Requester, window-buffer and memory-side signals of the scheduler.
// slave = scheduler view; master = surrounding control logic / memory view.
interface cnn_mem_scheduler_if;
    import cnn_mem_pkg::*;

    logic  ld_valid;
    addr_t ld_addr;
    data_t ld_data;
    logic  ld_ready;

    logic  win_req_valid;
    addr_t win_req_addr;
    logic  win_req_ready;

    logic  win_valid;
    win_t  win_data;
    logic  win_ready;
    logic  win_err;

    addr_t mem_address;
    data_t mem_data_in;
    logic  mem_write_enable;
    win_t  mem_data_out;

    modport slave (
        input  ld_valid, ld_addr, ld_data, win_req_valid, win_req_addr,
               win_ready, mem_data_out,
        output ld_ready, win_req_ready, win_valid, win_data, win_err,
               mem_address, mem_data_in, mem_write_enable
    );

    modport master (
        output ld_valid, ld_addr, ld_data, win_req_valid, win_req_addr,
               win_ready, mem_data_out,
        input  ld_ready, win_req_ready, win_valid, win_data, win_err,
               mem_address, mem_data_in, mem_write_enable
    );
endinterface

// File: rtl/cnn_mem_arb.sv
// One-grant-per-cycle arbiter between loader writes and window reads.
// Loader has priority, but a waiting window gets in after WR_BURST loader grants.
module cnn_mem_arb
    import cnn_mem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ld_valid,
    input  logic win_req_valid,
    input  logic rd_stage,
    input  logic win_valid,
    input  logic win_ready,
    output logic grant_ld,
    output logic grant_win
);
    logic [STRK_W-1:0] streak_q, streak_d;
    logic              win_elig;

    always_comb begin
        win_elig  = win_req_valid & ~rd_stage & (~win_valid | win_ready);
        grant_ld  = rst_n & ld_valid & (~win_elig | (streak_q < WR_BURST_C));
        grant_win = rst_n & win_elig & ~grant_ld;

        streak_d = streak_q;
        if (grant_win || !win_elig)
            streak_d = '0;
        else if (grant_ld && streak_q < WR_BURST_C)
            streak_d = streak_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) streak_q <= '0;
        else        streak_q <= streak_d;
    end
endmodule

// File: rtl/cnn_mem_scheduler.sv
// Shares the CNN memory between loader writes and 5x5 window reads; all memory
// control is registered and each read lands in a single-entry window buffer.
module cnn_mem_scheduler
    import cnn_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    cnn_mem_scheduler_if.slave   bus,
    output logic                 busy
);
    logic  grant_ld, grant_win;
    addr_t mem_address_q, mem_address_d;
    data_t mem_data_in_q, mem_data_in_d;
    logic  mem_we_q, mem_we_d;
    logic  rd_stage_q, rd_stage_d;
    logic  win_valid_q, win_valid_d;
    win_t  win_data_q, win_data_d;
    logic  win_err_q, win_err_d;

    cnn_mem_arb u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_valid      (bus.ld_valid),
        .win_req_valid (bus.win_req_valid),
        .rd_stage      (rd_stage_q),
        .win_valid     (win_valid_q),
        .win_ready     (bus.win_ready),
        .grant_ld      (grant_ld),
        .grant_win     (grant_win)
    );

    always_comb begin
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_we_d      = 1'b0;
        rd_stage_d    = 1'b0;
        win_err_d     = 1'b0;
        win_valid_d   = win_valid_q & ~bus.win_ready;
        win_data_d    = win_data_q;

        if (grant_ld) begin
            mem_address_d = bus.ld_addr;
            mem_data_in_d = bus.ld_data;
            mem_we_d      = 1'b1;
        end else if (grant_win) begin
            // Out-of-range bases still consume the grant but never touch memory.
            if (win_in_range(bus.win_req_addr)) begin
                mem_address_d = bus.win_req_addr;
                rd_stage_d    = 1'b1;
            end else begin
                win_err_d = 1'b1;
            end
        end

        // Capture beats a same-edge drain so the fresh window is never lost.
        if (rd_stage_q) begin
            win_data_d  = bus.mem_data_out;
            win_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
            rd_stage_q    <= 1'b0;
            win_valid_q   <= 1'b0;
            win_data_q    <= '0;
            win_err_q     <= 1'b0;
        end else begin
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
            rd_stage_q    <= rd_stage_d;
            win_valid_q   <= win_valid_d;
            win_data_q    <= win_data_d;
            win_err_q     <= win_err_d;
        end
    end

    assign bus.ld_ready         = grant_ld;
    assign bus.win_req_ready    = grant_win;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_data_in      = mem_data_in_q;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.win_valid        = win_valid_q;
    assign bus.win_data         = win_data_q;
    assign bus.win_err          = win_err_q;
    assign busy = mem_we_q | rd_stage_q | bus.ld_valid | bus.win_req_valid;
endmodule

// File: tb/tb_cnn_mem_scheduler.sv
// Directed bench for cnn_mem_scheduler with a behavioural 64K-word memory
// that writes on the clock edge and returns a combinational 25-word window.
module tb_cnn_mem_scheduler;
    import cnn_mem_pkg::*;

    logic clk, rst_n, busy;
    cnn_mem_scheduler_if bus ();

    cnn_mem_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

    logic [15:0] mem [0:65535] = '{default: 16'h0000};

    always @(posedge clk)
        if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_data_in;

    always_comb begin
        bus.mem_data_out = '0;
        for (int i = 0; i < TAPS; i++)
            bus.mem_data_out[i*DATA_W +: DATA_W] = mem[16'(bus.mem_address + 16'(i))];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ldv;
        logic [15:0] la, ld;
        logic        wrv;
        logic [15:0] wa;
        logic        wrdy;
        logic        e_ldr, e_wrr, e_we, e_wv, e_err, cw;
        logic [15:0] e_w0, e_w24;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic ldv, logic [15:0] la, logic [15:0] ld,
                                logic wrv, logic [15:0] wa, logic wrdy,
                                logic e_ldr, logic e_wrr, logic e_we, logic e_wv,
                                logic e_err, logic cw, logic [15:0] e_w0,
                                logic [15:0] e_w24);
        vec_t v;
        v.ldv = ldv; v.la = la; v.ld = ld; v.wrv = wrv; v.wa = wa; v.wrdy = wrdy;
        v.e_ldr = e_ldr; v.e_wrr = e_wrr; v.e_we = e_we; v.e_wv = e_wv;
        v.e_err = e_err; v.cw = cw; v.e_w0 = e_w0; v.e_w24 = e_w24;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ldv, input logic [15:0] la, input logic [15:0] ld,
                         input logic wrv, input logic [15:0] wa, input logic wrdy);
        bus.ld_valid      = ldv;
        bus.ld_addr       = la;
        bus.ld_data       = ld;
        bus.win_req_valid = wrv;
        bus.win_req_addr  = wa;
        bus.win_ready     = wrdy;
    endtask

    // Called at posedge+1: drive, check grants, step one edge, check registers.
    task automatic apply(input vec_t v, input string tag);
        drive(v.ldv, v.la, v.ld, v.wrv, v.wa, v.wrdy);
        #1;
        chk({tag, ".ld_ready"}, 32'(bus.ld_ready), 32'(v.e_ldr));
        chk({tag, ".win_req_ready"}, 32'(bus.win_req_ready), 32'(v.e_wrr));
        @(posedge clk);
        #1;
        chk({tag, ".mem_we"}, 32'(bus.mem_write_enable), 32'(v.e_we));
        chk({tag, ".win_valid"}, 32'(bus.win_valid), 32'(v.e_wv));
        chk({tag, ".win_err"}, 32'(bus.win_err), 32'(v.e_err));
        if (v.cw) begin
            chk({tag, ".word0"}, 32'(bus.win_data[15:0]), 32'(v.e_w0));
            chk({tag, ".word24"}, 32'(bus.win_data[399:384]), 32'(v.e_w24));
        end
    endtask

    initial begin
        // Write 0x0001..0x0019 to 0x0100..0x0118, read it back, hold, drain.
        for (int i = 0; i < TAPS; i++)
            tbl.push_back(mk(1, 16'h0100 + 16'(i), 16'(i + 1), 0, 0, 0,
                             1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 16'h0100, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0001, 16'h0019));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0001, 16'h0019));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset with a loader write pending: no grants, all outputs cleared.
        drive(1, 16'h0010, 16'hBEEF, 1, 16'h0100, 0);
        rst_n = 1'b0;
        #2;
        chk("rst.ld_ready", 32'(bus.ld_ready), 0);
        chk("rst.win_req_ready", 32'(bus.win_req_ready), 0);
        chk("rst.mem_we", 32'(bus.mem_write_enable), 0);
        chk("rst.mem_address", 32'(bus.mem_address), 0);
        chk("rst.win_valid", 32'(bus.win_valid), 0);
        chk("rst.win_data", 32'(bus.win_data[31:0]), 0);
        chk("rst.win_err", 32'(bus.win_err), 0);
        chk("rst.busy", 32'(busy), 1);

        // Release, accept write to 0x0010, then reset before it commits.
        #4;
        rst_n = 1'b1;
        drive(1, 16'h0010, 16'hBEEF, 0, 0, 0);
        #1;
        chk("midwr.ld_ready", 32'(bus.ld_ready), 1);
        @(posedge clk);
        #1;
        chk("midwr.mem_we", 32'(bus.mem_write_enable), 1);
        chk("midwr.mem_address", 32'(bus.mem_address), 32'h0010);
        chk("midwr.mem_data_in", 32'(bus.mem_data_in), 32'hBEEF);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("midwr.rst_we", 32'(bus.mem_write_enable), 0);
        chk("midwr.rst_addr", 32'(bus.mem_address), 0);
        chk("midwr.rst_din", 32'(bus.mem_data_in), 0);
        @(posedge clk);
        #1;
        chk("midwr.mem_0010", 32'(mem[16'h0010]), 0);
        rst_n = 1'b1;

        foreach (tbl[k]) apply(tbl[k], $sformatf("tbl%0d", k));

        // Fairness: loader and window both pending, window buffer empty.
        for (int c = 0; c < 4; c++)
            apply(mk(1, 16'h0200 + 16'(c), 16'h5000 + 16'(c), 1, 16'h0100, 0,
                     1, 0, 1, 0, 0, 0, 0, 0), $sformatf("fair%0d", c));
        apply(mk(1, 16'h0204, 16'h5004, 1, 16'h0100, 0, 0, 1, 0, 0, 0, 0, 0, 0), "fair4");
        apply(mk(1, 16'h0204, 16'h5004, 1, 16'h0100, 0,
                 1, 0, 1, 1, 0, 1, 16'h0001, 16'h0019), "fair5");

        // Back-pressure: buffer full and not drained, loader keeps going.
        for (int c = 0; c < 3; c++)
            apply(mk(1, 16'h0205 + 16'(c), 16'h6000 + 16'(c), 1, 16'h0100, 0,
                     1, 0, 1, 1, 0, 0, 0, 0), $sformatf("bp%0d", c));
        apply(mk(0, 0, 0, 1, 16'h0100, 1, 0, 1, 0, 0, 0, 0, 0, 0), "bp_release");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0001, 16'h0019), "bp_capture");

        // Boundary: seed the first and last words of the top-most window.
        apply(mk(1, 16'hFFE7, 16'h1234, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0), "bnd_wr0");
        apply(mk(1, 16'hFFFF, 16'hA5A5, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0), "bnd_wr1");
        apply(mk(0, 0, 0, 1, 16'hFFE7, 1, 0, 1, 0, 0, 0, 0, 0, 0), "bnd_acc");
        // win_ready held high across the capture edge: capture must win.
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 16'h1234, 16'hA5A5), "bnd_cap");
        chk("bnd.mem_address", 32'(bus.mem_address), 32'hFFE7);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h1234, 16'hA5A5), "bnd_hold");

        // 65512 is one past the limit: error pulse, memory and buffer data untouched.
        apply(mk(0, 0, 0, 1, 16'hFFE8, 1, 0, 1, 0, 0, 1, 1, 16'h1234, 16'hA5A5), "oor_acc");
        chk("oor.mem_address", 32'(bus.mem_address), 32'hFFE7);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1234, 16'hA5A5), "oor_after");
        chk("idle.busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cnn_mem_scheduler.md
Name: cnn_mem_scheduler

Overview:
Sequences and shares the CNN weight/feature memory (16-bit words, 16-bit address, 25-word window read) between two requesters: the IO loader, which issues single-word writes, and the convolution engine, which issues 5x5 window reads at a base address. It drives the memory's address, write-data and write-enable ports from registered state. It captures the combinational 400-bit window into an output buffer with a valid/ready handshake. It sits between the IO/conv control logic and the CNN memory instance.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory word width
TAPS, 25, words per window (5x5 kernel)
WR_BURST, 4, max consecutive loader grants while a window request waits

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  loader has a write pending
ld_addr  in  ADDR_W  loader write address
ld_data  in  DATA_W  loader write data
ld_ready  out  1  loader write accepted this cycle (ld_valid & ld_ready)
win_req_valid  in  1  conv engine requests a window
win_req_addr  in  ADDR_W  window base address
win_req_ready  out  1  window request accepted this cycle
win_valid  out  1  window buffer holds data
win_data  out  DATA_W*TAPS  buffered window; word i at bits [(i+1)*16-1:i*16] = mem[base+i]
win_ready  in  1  consumer takes buffer (win_valid & win_ready)
win_err  out  1  one-cycle pulse: rejected out-of-range window
mem_address  out  ADDR_W  to memory address
mem_data_in  out  DATA_W  to memory write data
mem_write_enable  out  1  to memory write enable
mem_data_out  in  DATA_W*TAPS  combinational window from memory
busy  out  1  any memory operation issued or in flight

Behaviour:
- Reset (async, rst_n=0): mem_address=0, mem_data_in=0, mem_write_enable=0, win_valid=0, win_data=0, win_err=0, streak counter=0, rd_stage=0. A write registered but not yet clocked into memory is dropped. ld_ready and win_req_ready are 0 during reset.
- One grant per cycle, decided combinationally from registered state:
  - Window eligible = win_req_valid & ~rd_stage & (~win_valid | win_ready).
  - Loader wins if ld_valid and (not window eligible, or streak < WR_BURST).
  - Otherwise the window wins if eligible.
- Streak counter:
  - Increments on each loader grant while the window is eligible.
  - Clears on a window grant, or on any cycle the window is not eligible.
  - Saturates at WR_BURST.
- Write, accepted in cycle N: at edge end-of-N, mem_address<=ld_addr, mem_data_in<=ld_data, mem_write_enable<=1. Memory commits at edge end-of-N+1.
- Window, accepted in cycle N with win_req_addr <= 2^ADDR_W - TAPS (65511):
  - At edge end-of-N: mem_address<=base, mem_write_enable<=0, rd_stage<=1.
  - At edge end-of-N+1: win_data<=mem_data_out, win_valid<=1, rd_stage<=0.
  - Latency: request accept to win_valid = 2 cycles.
- Window out of range (base > 65511): accepted normally, no memory access, win_err=1 during cycle N+1 only. win_data and win_valid are unchanged. Counts as a window grant for fairness.
- Idle cycle (no grant): mem_write_enable<=0; mem_address and mem_data_in hold.
- Buffer: win_valid clears on win_valid & win_ready unless a capture occurs at the same edge, in which case the capture wins and win_valid stays 1. Only one window is in flight or held at a time.
- Ordering: grants execute in acceptance order. A read accepted after a write to an overlapping address returns the new data, because the write commits at end-of-N+1 and the read captures no earlier than end-of-N+2.
- busy = mem_write_enable | rd_stage | ld_valid | win_req_valid.

Decomposition:
- Package cnn_mem_pkg: ADDR_W, DATA_W, TAPS, WIN_W=DATA_W*TAPS, WIN_MAX_BASE=2^ADDR_W-TAPS.
- One natural sub-module, cnn_mem_arb: grant selection plus streak counter. Outputs grant_ld and grant_win.
- Datapath registers and the window buffer stay in the top module.

Test Plan:
- Reset mid-write: ld_valid=1, addr=0x0010, data=0xBEEF accepted; assert rst_n=0 before the next edge -> mem_write_enable=0; mem[0x0010] unchanged; all outputs at reset values.
- Write then window: write 0x0001..0x0019 to addr 0x0100..0x0118, then request base 0x0100 -> win_valid 2 cycles after accept; win_data word0=0x0001, word24=0x0019.
- Fairness: ld_valid held high with win_req_valid=1 -> exactly 4 ld_ready cycles, then win_req_ready=1 for 1 cycle, then loader resumes.
- Back-pressure: win_ready=0 with buffer full -> win_req_ready stays 0; the loader keeps writing every cycle. Raise win_ready -> next request is accepted the same cycle.
- Boundary: base 65511 -> valid window (word24 = mem[65535]). Base 65512 -> win_err pulses 1 cycle; win_valid and win_data unchanged; mem_address not updated.
- Simultaneous drain and capture: win_ready=1 on the capture edge -> win_valid stays 1 and win_data shows the new window.
